// File: rtl/rtc_bus_reader.sv
`default_nettype none
// ============================================================================
// rtc_bus_reader : runs the multiplexed AD-bus cycles to the external RTC
//   (transfer-command write, then a 9-register scan) and publishes each byte.
//   Optional macro RTC_BCD_CHECK_EN: drop non-BCD bytes and flag bcd_err.
// Revision: 1.0
// ============================================================================
module rtc_bus_reader #(
  parameter int unsigned T_PULSE  = 10,
  parameter int unsigned T_REC    = 5,
  parameter logic [7:0]  CMD_ADDR = 8'hF0
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       rtc_ad,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [3:0] posicion,
  output logic [7:0] dato,
  output logic       read,
  output logic       busy,
  output logic       done
`ifdef RTC_BCD_CHECK_EN
  ,
  output logic       bcd_err
`endif
);

  localparam logic [7:0] PULSE_LAST = 8'(T_PULSE - 1);
  localparam logic [7:0] REC_LAST   = 8'(T_REC - 1);

  typedef enum logic [3:0] {
    IDLE, A_SET, A_PULSE, A_REC, D_SET, D_PULSE, D_REC, PUBLISH, NEXT
  } state_t;

  state_t     state_q, state_d;
  logic       cmd_q, cmd_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cap_q, cap_d;
  logic [3:0] pos_q, pos_d;
  logic [7:0] dato_q, dato_d;
  logic       pub_ok;

  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d, rtc_ad_q, rtc_ad_d;
  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic       read_q, busy_q, done_q;

  function automatic logic [7:0] reg_addr(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      4'd8:    return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    pos_d   = pos_q;
    dato_d  = dato_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = A_SET;
        cmd_d   = 1'b1;
        idx_d   = 4'd0;
      end
      A_SET: begin
        state_d = A_PULSE;
        cnt_d   = 8'd0;
      end
      A_PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = A_REC;
        cnt_d   = 8'd0;
      end else cnt_d = cnt_q + 8'd1;
      A_REC: if (cnt_q == REC_LAST) begin
        state_d = D_SET;
        cnt_d   = 8'd0;
      end else cnt_d = cnt_q + 8'd1;
      D_SET: begin
        state_d = D_PULSE;
        cnt_d   = 8'd0;
      end
      D_PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = D_REC;
        cnt_d   = 8'd0;
        if (!cmd_q) cap_d = ad_in;
      end else cnt_d = cnt_q + 8'd1;
      D_REC: if (cnt_q == REC_LAST) begin
        cnt_d = 8'd0;
        if (cmd_q) begin
          cmd_d   = 1'b0;
          state_d = A_SET;
        end else begin
          // dato/posicion load on entry so they are valid alongside read
          state_d = PUBLISH;
          if (pub_ok) begin
            dato_d = cap_q;
            pos_d  = idx_q;
          end
        end
      end else cnt_d = cnt_q + 8'd1;
      // PUBLISH chains straight into the next address phase; NEXT only closes the scan
      PUBLISH: if (idx_q == 4'd8) state_d = NEXT;
      else begin
        idx_d   = idx_q + 4'd1;
        state_d = A_SET;
      end
      NEXT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus pins are registered from the next state so they leave the block glitch-free
  always_comb begin
    ad_out_d = 8'h00;
    ad_oe_d  = 1'b0;
    rtc_ad_d = 1'b1;
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    case (state_d)
      A_SET, A_PULSE, A_REC: begin
        ad_oe_d  = 1'b1;
        rtc_ad_d = 1'b0;
        ad_out_d = cmd_d ? CMD_ADDR : reg_addr(idx_d);
        if (state_d == A_PULSE) begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
      end
      D_SET: ad_oe_d = cmd_d;
      D_PULSE: begin
        ad_oe_d = cmd_d;
        cs_n_d  = 1'b0;
        if (cmd_d) wr_n_d = 1'b0;
        else       rd_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q  <= IDLE;
      cmd_q    <= 1'b0;
      idx_q    <= 4'd0;
      cnt_q    <= 8'd0;
      cap_q    <= 8'h00;
      pos_q    <= 4'd0;
      dato_q   <= 8'h00;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      rtc_ad_q <= 1'b1;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      pos_q    <= pos_d;
      dato_q   <= dato_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      rtc_ad_q <= rtc_ad_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      read_q   <= (state_d == PUBLISH) && pub_ok;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == NEXT);
    end
  end

`ifdef RTC_BCD_CHECK_EN
  logic bcd_err_q;
  assign pub_ok = (cap_q[7:4] <= 4'd9) && (cap_q[3:0] <= 4'd9);
  always_ff @(posedge reloj) begin
    if (resetM)                              bcd_err_q <= 1'b0;
    else if (state_q == IDLE && start)       bcd_err_q <= 1'b0;
    else if (state_d == PUBLISH && !pub_ok)  bcd_err_q <= 1'b1;
  end
  assign bcd_err = bcd_err_q;
`else
  assign pub_ok = 1'b1;
`endif

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign rtc_ad   = rtc_ad_q;
  assign rtc_cs_n = cs_n_q;
  assign rtc_rd_n = rd_n_q;
  assign rtc_wr_n = wr_n_q;
  assign posicion = pos_q;
  assign dato     = dato_q;
  assign read     = read_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_reader.sv
`default_nettype none
// tb_rtc_bus_reader: a default-timing and a short-timing instance checked against
// a bus-transaction model of the scan, plus literal timing/data expectations.
module tb_rtc_bus_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] start;
  logic       bad_mode;
  logic       mon_en;
  logic [7:0] ad_in  [2];
  logic [7:0] ad_out [2];
  logic [7:0] dato   [2];
  logic [3:0] pos    [2];
  logic [7:0] lat    [2];
  logic [1:0] ad_oe, rtc_ad, cs_n, rd_n, wr_n, rd, busy, done;
`ifdef RTC_BCD_CHECK_EN
  logic [1:0] bcd_err;
`endif

  rtc_bus_reader u_dut0 (
    .reloj(clk), .resetM(rst), .start(start[0]), .ad_in(ad_in[0]),
    .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .rtc_ad(rtc_ad[0]),
    .rtc_cs_n(cs_n[0]), .rtc_rd_n(rd_n[0]), .rtc_wr_n(wr_n[0]),
    .posicion(pos[0]), .dato(dato[0]), .read(rd[0]), .busy(busy[0]), .done(done[0])
`ifdef RTC_BCD_CHECK_EN
    , .bcd_err(bcd_err[0])
`endif
  );

  rtc_bus_reader #(.T_PULSE(3), .T_REC(2)) u_dut1 (
    .reloj(clk), .resetM(rst), .start(start[1]), .ad_in(ad_in[1]),
    .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .rtc_ad(rtc_ad[1]),
    .rtc_cs_n(cs_n[1]), .rtc_rd_n(rd_n[1]), .rtc_wr_n(wr_n[1]),
    .posicion(pos[1]), .dato(dato[1]), .read(rd[1]), .busy(busy[1]), .done(done[1])
`ifdef RTC_BCD_CHECK_EN
    , .bcd_err(bcd_err[1])
`endif
  );

  // RTC device model: latch the address on an address-phase write, answer address+0x10
  function automatic logic [7:0] rtc_val(input logic [7:0] a, input logic bad);
    if (bad && a == 8'h23) return 8'h7A;
    return a + 8'h10;
  endfunction

  always @(posedge clk) begin
    if (!cs_n[0] && !wr_n[0] && !rtc_ad[0]) lat[0] <= ad_out[0];
    if (!cs_n[1] && !wr_n[1] && !rtc_ad[1]) lat[1] <= ad_out[1];
  end
  assign ad_in[0] = rtc_val(lat[0], bad_mode);
  assign ad_in[1] = rtc_val(lat[1], bad_mode);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pt(input int w); return (w == 0) ? 10 : 3; endfunction
  function automatic int rt(input int w); return (w == 0) ? 5 : 2; endfunction
  // access = address phase + data phase; each read adds one publish cycle
  function automatic int total(input int w);
    int acc;
    acc = 2 * (pt(w) + rt(w) + 1);
    return acc + 9 * (acc + 1);
  endfunction
  function automatic logic [7:0] exp_addr(input int k);
    return (k < 6) ? 8'(8'h21 + k) : 8'(8'h41 + k - 6);
  endfunction

  int       cyc[2], lowcnt[2], highcnt[2], txn[2], npub[2], ndone[2], done_cyc[2];
  bit       mbusy[2];
  bit [7:0] hold_dato[2], first_dato[2], last_dato[2];
  bit [3:0] hold_pos[2];

  task automatic mon(input int w);
    logic [11:0] act, expv;
    int k;
    cyc[w]++;
    if (mbusy[w] && cyc[w] > total(w)) mbusy[w] = 1'b0;
    chk("busy", 32'(busy[w]), 32'(mbusy[w]));
    chk("done", 32'(done[w]), 32'(mbusy[w] && cyc[w] == total(w)));
    chk("rd_wr_overlap", 32'(!rd_n[w] && !wr_n[w]), 32'd0);
    chk("oe_during_rd", 32'(!rd_n[w] && ad_oe[w]), 32'd0);
    chk("strobe_without_cs", 32'(cs_n[w] && !(rd_n[w] && wr_n[w])), 32'd0);
    if (!mbusy[w])
      chk("idle_bus", 32'({cs_n[w], rd_n[w], wr_n[w], ad_oe[w], rd[w]}), 32'b11100);
    if (!cs_n[w]) begin
      lowcnt[w]++;
      if (lowcnt[w] == 1 && txn[w] > 0)
        chk("recovery_gap", 32'(highcnt[w] >= rt(w) + 1), 32'd1);
      if (txn[w] == 0)      expv = {1'b1, 1'b0, 1'b0, 1'b1, 8'hF0};
      else if (txn[w] == 1) expv = {1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
      else begin
        k = (txn[w] - 2) / 2;
        if (txn[w] % 2 == 0) expv = {1'b1, 1'b0, 1'b0, 1'b1, exp_addr(k)};
        else                 expv = {1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      end
      act = {rd_n[w], wr_n[w], rtc_ad[w], ad_oe[w], ad_oe[w] ? ad_out[w] : 8'h00};
      chk("bus_txn", 32'(act), 32'(expv));
    end else begin
      if (lowcnt[w] > 0) begin
        chk("pulse_len", lowcnt[w], pt(w));
        txn[w]++;
        highcnt[w] = 0;
      end
      lowcnt[w] = 0;
      highcnt[w]++;
    end
    if (rd[w]) begin
      k = (bad_mode && npub[w] >= 2) ? npub[w] + 1 : npub[w];
      chk("posicion", 32'(pos[w]), k);
      chk("dato", 32'(dato[w]), 32'(exp_addr(k) + 8'h10));
      if (npub[w] == 0) first_dato[w] = dato[w];
      last_dato[w] = dato[w];
      hold_dato[w] = dato[w];
      hold_pos[w]  = pos[w];
      npub[w]++;
    end else begin
      chk("dato_hold", 32'({pos[w], dato[w]}), 32'({hold_pos[w], hold_dato[w]}));
    end
    if (done[w]) begin
      ndone[w]++;
      done_cyc[w] = cyc[w];
      chk("scan_reads", npub[w], bad_mode ? 8 : 9);
      chk("scan_pulses", txn[w], 20);
    end
    if (rst) begin
      mbusy[w] = 1'b0; lowcnt[w] = 0; highcnt[w] = 100;
      hold_pos[w] = 4'd0; hold_dato[w] = 8'h00;
    end else if (start[w] && !mbusy[w]) begin
      mbusy[w] = 1'b1; cyc[w] = -1; txn[w] = 0; npub[w] = 0;
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    mon(0);
    mon(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int w);
    start[w] = 1'b1;
    step(1);
    start[w] = 1'b0;
  endtask

  task automatic wait_done(input int w, input int budget);
    int base;
    base = ndone[w];
    for (int i = 0; i < budget && ndone[w] == base; i++) step(1);
    chk("done_timeout", 32'(ndone[w] > base), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 2'b00; bad_mode = 1'b0; mon_en = 1'b0;
    step(3);
    mon_en = 1'b1;
    rst = 1'b0;
    chk("rst_dato", 32'(dato[0]), 32'h00);
    chk("rst_pos", 32'(pos[0]), 32'd0);
    chk("rst_rtc_ad", 32'(rtc_ad[0]), 32'd1);
    chk("rst_ad_out", 32'(ad_out[0]), 32'h00);
`ifdef RTC_BCD_CHECK_EN
    chk("rst_bcd_err", 32'(bcd_err[0]), 32'd0);
`endif
    step(20);

    // full scan with ignored restarts at cycles 50 and 200
    pulse_start(0);
    step(49);  pulse_start(0);
    step(149); pulse_start(0);
    wait_done(0, 1000);
    chk("scan0_cycles", done_cyc[0], 329);
    chk("scan0_reads", npub[0], 9);
    chk("scan0_first", 32'(first_dato[0]), 32'h31);
    chk("scan0_last", 32'(last_dato[0]), 32'h53);
    step(30);
    chk("scan0_done_once", ndone[0], 1);

    // short strobe timing
    pulse_start(1);
    wait_done(1, 500);
    chk("scan1_cycles", done_cyc[1], 129);
    chk("scan1_reads", npub[1], 9);
    chk("scan1_last", 32'(last_dato[1]), 32'h53);

    // reset during the data pulse of index 4
    pulse_start(0);
    for (int i = 0; i < 1000 && !(txn[0] == 11 && lowcnt[0] >= 2); i++) step(1);
    chk("pre_rst_rd_low", 32'(rd_n[0]), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_strobes", 32'({cs_n[0], rd_n[0], busy[0]}), 32'b110);
    chk("rst_mid_reads", npub[0], 4);
    step(5);

    // reset wins over a simultaneous start
    rst = 1'b1; start[0] = 1'b1;
    step(1);
    rst = 1'b0; start[0] = 1'b0;
    chk("rst_beats_start", 32'(busy[0]), 32'd0);
    step(3);

    pulse_start(0);
    wait_done(0, 1000);
    chk("restart_cycles", done_cyc[0], 329);
    chk("restart_reads", npub[0], 9);

`ifdef RTC_BCD_CHECK_EN
    step(5);
    bad_mode = 1'b1;
    pulse_start(0);
    wait_done(0, 1000);
    chk("bcd_reads", npub[0], 8);
    chk("bcd_err_set", 32'(bcd_err[0]), 32'd1);
    step(3);
    bad_mode = 1'b0;
    pulse_start(0);
    chk("bcd_err_cleared", 32'(bcd_err[0]), 32'd0);
    wait_done(0, 1000);
    chk("bcd_clean_reads", npub[0], 9);
`endif

    step(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
